// File: rtl/mvm_result_buffer_if.sv
// Handshake bundle between the MVM result producer, the result buffer and its consumer.
// The slave modport is the buffer side; the master modport is the producer/consumer side.
interface mvm_result_buffer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 64
);
  logic                       done;
  logic [IN_WIDTH-1:0]        data_in;
  logic                       relu_en;
  logic                       can_start;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_WIDTH-1:0]       out_data;
  logic                       out_last;
  logic                       overflow;
  logic [$clog2(DEPTH):0]     count;

  modport slave (
    input  done, data_in, relu_en, out_ready,
    output can_start, out_valid, out_data, out_last, overflow, count
  );

  modport master (
    output done, data_in, relu_en, out_ready,
    input  can_start, out_valid, out_data, out_last, overflow, count
  );
endinterface

// File: rtl/mvm_result_buffer.sv
// Captures M-word MVM result bursts, requantizes each word (shift, optional ReLU,
// saturate) and queues them in a first-word-fall-through FIFO for a ready/valid consumer.
module mvm_result_buffer #(
  parameter int M         = 32,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 2,
  parameter int DEPTH     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  mvm_result_buffer_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int JW = (M > 1) ? $clog2(M) : 1;
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(-(1 <<< (OUT_WIDTH - 1)));

  typedef enum logic {S_IDLE, S_CAPTURE} state_t;

  state_t                r_state;
  logic [JW-1:0]         r_j;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic [OUT_WIDTH:0]    r_mem [DEPTH];

  logic                          w_capture;
  logic                          w_valid;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_wr;
  logic                          w_last;
  logic signed [IN_WIDTH-1:0]    w_shift;
  logic signed [IN_WIDTH-1:0]    w_relu;
  logic [OUT_WIDTH-1:0]          w_sat;
  logic [OUT_WIDTH:0]            w_head;

  assign w_capture = (r_state == S_CAPTURE);
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid && bus.out_ready;
  assign w_full    = (r_count == CW'(DEPTH));
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign w_wr      = w_capture && (!w_full || w_pop);
  assign w_last    = (r_j == JW'(M - 1));

  assign w_shift = $signed(bus.data_in) >>> SHIFT;

  always_comb begin
    w_relu = w_shift;
    if (bus.relu_en && (w_shift < 0)) w_relu = '0;
    if (w_relu > SAT_MAX)      w_sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (w_relu < SAT_MIN) w_sat = SAT_MIN[OUT_WIDTH-1:0];
    else                       w_sat = w_relu[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.done) begin
            r_state <= S_CAPTURE;
            r_j     <= '0;
          end
        end
        S_CAPTURE: begin
          // The word index advances even when the word is dropped.
          if (w_last) begin
            r_state <= S_IDLE;
            r_j     <= '0;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_capture && !w_wr) r_ovf <= 1'b1;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;

      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {w_last, w_sat};
  end

  assign w_head = r_mem[r_rptr];

  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_head[OUT_WIDTH-1:0] : '0;
  assign bus.out_last  = w_valid ? w_head[OUT_WIDTH] : 1'b0;
  assign bus.overflow  = r_ovf;
  assign bus.count     = r_count;
  // count never exceeds DEPTH, so the sum fits in one extra bit.
  assign bus.can_start = (({1'b0, r_count} + (CW + 1)'(M)) <= (CW + 1)'(DEPTH));
endmodule

// File: tb/tb_mvm_result_buffer.sv
// Randomized scoreboard bench for mvm_result_buffer: a reference model queues the expected
// requantized words, and a monitor compares every DUT output against it each cycle.
module tb_mvm_result_buffer;
  localparam int M      = 32;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 2;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mvm_result_buffer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH)) bus ();

  mvm_result_buffer #(
    .M(M), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [OUT_W:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  burst_left = 0;
  bit  ovf_exp = 1'b0;
  bit  rand_ready = 1'b0;
  int  n_bursts = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference requantizer: floor division by 2^SHIFT, ReLU, saturation, on plain integers.
  function automatic logic [OUT_W-1:0] ref_q(input logic [IN_W-1:0] d, input logic relu);
    int v, dv, s, hi, lo;
    v  = int'($signed(d));
    dv = 1 << SHIFT;
    if (v >= 0) s = v / dv;
    else        s = -((-v + dv - 1) / dv);
    if (relu && s < 0) s = 0;
    hi = (1 << (OUT_W - 1)) - 1;
    lo = -(1 << (OUT_W - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return OUT_W'(s);
  endfunction

  // Reference model: a done starts M word captures on the following M edges;
  // each captured word is kept if the stored count (after any same-edge pop) has room.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        if (burst_left > 0) begin
          int idx;
          idx = M - burst_left;
          if (exp_q.size() < DEPTH)
            exp_q.push_back({(idx == M - 1), ref_q(bus.data_in, bus.relu_en)});
          else
            ovf_exp = 1'b1;
          burst_left--;
        end else if (bus.done) begin
          burst_left = M;
        end
      end
    end
  end

  // Monitor: compare status and head word each cycle; pop when the consumer accepts.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("count", int'(bus.count), exp_q.size());
        check("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
        check("overflow", int'(bus.overflow), int'(ovf_exp));
        check("can_start", int'(bus.can_start), int'((DEPTH - exp_q.size()) >= M));
        if (bus.out_valid && exp_q.size() != 0) begin
          check("out_data", int'($signed(bus.out_data)), int'($signed(exp_q[0][OUT_W-1:0])));
          check("out_last", int'(bus.out_last), int'(exp_q[0][OUT_W]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Starts at posedge+1; leaves at posedge+1 after the last capture edge.
  task automatic burst(input int mode, input int nwords, input bit ready_on_cap);
    logic [IN_W-1:0] d;
    logic            r;
    n_bursts++;
    $display("burst %0d: mode %0d, %0d words, out_ready %0d", n_bursts, mode, nwords, bus.out_ready);
    bus.done = 1'b1;
    @(posedge clk); #1;
    bus.done = 1'b0;
    if (ready_on_cap) bus.out_ready = 1'b1;
    for (int j = 0; j < nwords; j++) begin
      d = IN_W'($urandom);
      r = 1'($urandom_range(0, 1));
      if (mode == 0) begin
        d = IN_W'(4 * j);
        r = 1'b0;
      end else if (mode == 1) begin
        case (j)
          0: begin d = 16'h7FFF; r = 1'b0; end
          1: begin d = 16'h8000; r = 1'b0; end
          2: begin d = -16'sd5;  r = 1'b0; end
          3: begin d = -16'sd5;  r = 1'b1; end
          4: begin d = 16'h8000; r = 1'b1; end
          5: begin d = 16'h0203; r = 1'b0; end
          6: begin d = 16'h01FF; r = 1'b0; end
          7: begin d = 16'hFE00; r = 1'b0; end
          default: ;
        endcase
      end
      bus.data_in = d;
      bus.relu_en = r;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4 * DEPTH && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_can_start();
    int c;
    for (c = 0; c < 500 && !bus.can_start; c++) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    if (!bus.can_start) begin
      n_checks++;
      n_fail++;
      $display("FAIL can_start_timeout: got 0, expected 1 within 500 cycles");
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge, then released after one edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    exp_q.delete();
    burst_left = 0;
    ovf_exp = 1'b0;
    #1;
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_count"}, int'(bus.count), 0);
    check({tag, "_overflow"}, int'(bus.overflow), 0);
    check({tag, "_can_start"}, int'(bus.can_start), 1);
    check({tag, "_out_data"}, int'(bus.out_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.done = 1'b1;
    bus.data_in = '0;
    bus.relu_en = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_can_start", int'(bus.can_start), 1);
    check("rst_out_last", int'(bus.out_last), 0);
    // done is held high across an edge during reset; nothing may be captured.
    @(posedge clk); #1;
    bus.done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_count", int'(bus.count), 0);

    bus.out_ready = 1'b1;
    burst(0, M, 1'b0);
    drain();
    burst(1, M, 1'b0);
    drain();

    rand_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      wait_can_start();
      burst(2, M, 1'b0);
    end
    drain();

    // Backpressure: two bursts fill the FIFO, the third is dropped entirely.
    bus.out_ready = 1'b0;
    burst(2, M, 1'b0);
    check("bp_count1", int'(bus.count), M);
    check("bp_can_start1", int'(bus.can_start), 1);
    burst(2, M, 1'b0);
    check("bp_count2", int'(bus.count), 2 * M);
    check("bp_can_start2", int'(bus.can_start), 0);
    burst(2, M, 1'b0);
    check("bp_overflow", int'(bus.overflow), 1);
    check("bp_count3", int'(bus.count), 2 * M);
    drain();

    // Full FIFO with the consumer popping every capture edge: nothing is dropped.
    do_reset("rst_a");
    bus.out_ready = 1'b0;
    burst(2, M, 1'b0);
    burst(2, M, 1'b0);
    check("fp_count_before", int'(bus.count), 2 * M);
    burst(2, M, 1'b1);
    bus.out_ready = 1'b0;
    check("fp_count_after", int'(bus.count), 2 * M);
    check("fp_overflow", int'(bus.overflow), 0);
    drain();

    // Reset after 10 captured words, then a fresh full vector.
    bus.out_ready = 1'b1;
    burst(2, 10, 1'b0);
    #1;
    do_reset("rst_mid");
    burst(2, M, 1'b0);
    drain();
    rand_ready = 1'b1;
    burst(2, M, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
